// File: rtl/framing_encoding.sv
// 802.15.4-style PHY framer: buffers PHR+PSDU bytes and serialises
// preamble, SFD, PHR and PSDU LSB first, one bit per clock.
module framing_encoding #(
    parameter int unsigned PREAMBLE_BYTES = 4,
    parameter logic [7:0]  SFD_VALUE      = 8'hA7,
    parameter int unsigned MAX_PSDU       = 127
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] phr_psdu_in,
    input  logic       phr_psdu_in_valid,
    output logic       framing_encoding_out,
    output logic       framing_encoding_out_valid
);
    localparam int unsigned DEPTH = MAX_PSDU + 1;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = $clog2(DEPTH + 1);
    localparam int unsigned CW    = (PREAMBLE_BYTES > 1) ? $clog2(PREAMBLE_BYTES) : 1;

    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, PHR, PSDU} state_t;

    state_t        state, state_nx;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [2:0]    bit_idx;
    logic [CW-1:0] pre_cnt;
    logic [6:0]    len;
    logic [7:0]    rd_byte;
    logic          byte_last, capture, underrun, mem_we;
    logic [AW-1:0] mem_idx;

    assign byte_last = (bit_idx == 3'd7);
    assign rd_byte   = mem[rd_ptr[AW-1:0]];

    // Only PHR plus len PSDU bytes are kept; anything beyond is dropped.
    assign capture  = phr_psdu_in_valid && (state != IDLE)
                      && (32'(wr_ptr) <= 32'(len)) && (32'(wr_ptr) < DEPTH);
    assign mem_we   = (state == IDLE) ? phr_psdu_in_valid : capture;
    assign mem_idx  = (state == IDLE) ? '0 : wr_ptr[AW-1:0];
    assign underrun = (state == PSDU) && (bit_idx == 3'd0) && (rd_ptr >= wr_ptr);

    always_comb begin
        state_nx                   = state;
        framing_encoding_out       = 1'b0;
        framing_encoding_out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (phr_psdu_in_valid) state_nx = PREAMBLE;
            end
            PREAMBLE: begin
                framing_encoding_out_valid = 1'b1;
                if (byte_last && (pre_cnt == CW'(PREAMBLE_BYTES - 1))) state_nx = SFD;
            end
            SFD: begin
                framing_encoding_out_valid = 1'b1;
                framing_encoding_out       = SFD_VALUE[bit_idx];
                if (byte_last) state_nx = PHR;
            end
            PHR: begin
                framing_encoding_out_valid = 1'b1;
                framing_encoding_out       = rd_byte[bit_idx];
                if (byte_last) state_nx = (len == 7'd0) ? IDLE : PSDU;
            end
            PSDU: begin
                if (underrun) begin
                    state_nx = IDLE;
                end else begin
                    framing_encoding_out_valid = 1'b1;
                    framing_encoding_out       = rd_byte[bit_idx];
                    if (byte_last && (32'(rd_ptr) == 32'(len))) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n && mem_we) mem[mem_idx] <= phr_psdu_in;
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            bit_idx <= '0;
            pre_cnt <= '0;
            len     <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                bit_idx <= '0;
                pre_cnt <= '0;
                rd_ptr  <= '0;
                if (phr_psdu_in_valid) begin
                    len    <= phr_psdu_in[6:0];
                    wr_ptr <= PW'(1);
                end
            end else begin
                if (capture) wr_ptr <= wr_ptr + PW'(1);
                bit_idx <= bit_idx + 3'd1;
                if (byte_last) begin
                    if (state == PREAMBLE) pre_cnt <= pre_cnt + CW'(1);
                    if (state == PHR || state == PSDU) rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_framing_encoding.sv
// Bench for framing_encoding: directed test-plan bursts plus random frames
// checked every cycle against a bit-position reference model.
module tb_framing_encoding;
    localparam int         PB  = 4;
    localparam logic [7:0] SFD = 8'hA7;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] phr_psdu_in = 8'h00;
    logic       phr_psdu_in_valid = 1'b0;
    logic       framing_encoding_out;
    logic       framing_encoding_out_valid;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int vcount = 0;

    // Reference model: frame start edge, captured bytes, abort flag.
    bit         m_busy = 1'b0;
    bit         m_abort = 1'b0;
    int         m_n0 = 0;
    int         m_len = 0;
    logic [7:0] cap[$];
    logic       exp_v, exp_b;

    framing_encoding #(
        .PREAMBLE_BYTES(PB),
        .SFD_VALUE(SFD),
        .MAX_PSDU(127)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .phr_psdu_in(phr_psdu_in),
        .phr_psdu_in_valid(phr_psdu_in_valid),
        .framing_encoding_out(framing_encoding_out),
        .framing_encoding_out_valid(framing_encoding_out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic bit_at(input int j);
        logic [7:0] tmp;
        if (j < 8 * PB) return 1'b0;
        if (j < 8 * (PB + 1)) begin
            tmp = SFD;
            return tmp[j % 8];
        end
        tmp = cap[j / 8 - (PB + 1)];
        return tmp[j % 8];
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic rst, input logic v, input logic [7:0] d);
        int  j;
        bit  prev;
        reset_n           = rst;
        phr_psdu_in_valid = v;
        phr_psdu_in       = d;
        @(posedge clk);
        edge_n++;
        prev = m_busy;
        if (rst) begin
            m_busy  = 1'b0;
            m_abort = 1'b0;
        end else if (!prev) begin
            if (v) begin
                m_n0    = edge_n;
                m_len   = int'(d[6:0]);
                m_abort = 1'b0;
                m_busy  = 1'b1;
                cap.delete();
                cap.push_back(d);
            end
        end else if (v && cap.size() <= m_len) begin
            cap.push_back(d);
        end
        exp_v = 1'b0;
        exp_b = 1'b0;
        if (m_busy) begin
            j = edge_n - m_n0;
            if (m_abort || j >= 8 * (PB + 2 + m_len)) begin
                m_busy = 1'b0;
            end else if (j >= 8 * (PB + 2) && j % 8 == 0 && (j / 8 - (PB + 1)) >= cap.size()) begin
                m_abort = 1'b1;
            end else begin
                exp_v = 1'b1;
                exp_b = bit_at(j);
            end
        end
        @(negedge clk);
        check_bit("out_valid", framing_encoding_out_valid, exp_v);
        check_bit("out", framing_encoding_out, exp_b);
        if (framing_encoding_out_valid === 1'b1) vcount++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic burst(input logic [7:0] bq[$]);
        foreach (bq[i]) cycle(1'b0, 1'b1, bq[i]);
    endtask

    initial begin
        logic [7:0] q[$];
        int         len, nb, guard;

        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h07);
        check_bit("reset_valid", framing_encoding_out_valid, 1'b0);
        check_bit("reset_out", framing_encoding_out, 1'b0);
        idle(2);

        vcount = 0;
        q = '{8'h07, 8'h03, 8'h01, 8'h05, 8'h21, 8'h43, 8'h65, 8'h87};
        burst(q);
        idle(110);
        check_int("nominal_len", vcount, 104);

        vcount = 0;
        q = '{8'h00};
        burst(q);
        idle(55);
        check_int("len0_len", vcount, 48);

        vcount = 0;
        q = '{8'h82, 8'hAA, 8'h55};
        burst(q);
        idle(70);
        check_int("phr7_len", vcount, 64);

        vcount = 0;
        q = '{8'h01, 8'h11, 8'h22, 8'h33};
        burst(q);
        idle(60);
        check_int("extra_len", vcount, 56);

        vcount = 0;
        q = '{8'h05, 8'h11, 8'h22};
        burst(q);
        idle(80);
        check_int("underrun_len", vcount, 64);

        vcount = 0;
        q = '{8'h03, 8'hAA, 8'hBB, 8'hCC};
        burst(q);
        idle(30);
        cycle(1'b1, 1'b0, 8'h00);
        check_bit("midreset_valid", framing_encoding_out_valid, 1'b0);
        check_int("midreset_len", vcount, 34);
        idle(2);
        vcount = 0;
        q = '{8'h07, 8'h03, 8'h01, 8'h05, 8'h21, 8'h43, 8'h65, 8'h87};
        burst(q);
        idle(110);
        check_int("after_reset_len", vcount, 104);

        vcount = 0;
        q.delete();
        q.push_back(8'h7F);
        for (int i = 0; i < 127; i++) q.push_back(8'($urandom));
        burst(q);
        idle(1000);
        check_int("max_len", vcount, 1064);

        for (int f = 0; f < 20; f++) begin
            len = int'($urandom_range(0, 20));
            cycle(1'b0, 1'b1, {1'($urandom_range(0, 1)), 7'(len)});
            nb = len + int'($urandom_range(0, 2));
            for (int k = 0; k < nb; k++) begin
                if ($urandom_range(0, 5) == 0) idle(int'($urandom_range(1, 40)));
                cycle(1'b0, 1'b1, 8'($urandom));
            end
            guard = 0;
            while (m_busy && guard < 3000) begin
                cycle(1'b0, 1'b0, 8'($urandom));
                guard++;
            end
            idle(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/framing_encoding.md
Name: framing_encoding

Overview:
- PHY framing/serialisation block for an IEEE 802.15.4-style transmitter.
- Accepts a PPDU payload as a burst of bytes: the PHR byte followed by the PSDU bytes.
- Buffers the burst and emits a serial bitstream: preamble, then SFD, then PHR, then PSDU. Bytes go out LSB first, one bit per clock.
- Sits between the MAC/PSDU byte source and the bit-level modulator/spreader.

Parameters:
- PREAMBLE_BYTES, 4, number of 0x00 preamble bytes sent before the SFD.
- SFD_VALUE, 8'hA7, start-of-frame delimiter byte.
- MAX_PSDU, 127, maximum PSDU length in bytes; the byte buffer depth is MAX_PSDU+1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  reset: one clock, synchronous, active-high (reset_n=1 resets on the next clk rising edge).
- phr_psdu_in  input  8  input byte; PHR first, then PSDU bytes.
- phr_psdu_in_valid  input  1  qualifies phr_psdu_in; one byte is accepted per clock while high.
- framing_encoding_out  output  1  serial framed bit.
- framing_encoding_out_valid  output  1  high while framing_encoding_out carries a frame bit.

Behaviour:
- Reset:
  - framing_encoding_out=0, framing_encoding_out_valid=0.
  - FSM to IDLE; write and read pointers, bit counter and length register cleared.
- FSM states: IDLE, PREAMBLE, SFD, PHR, PSDU.
- IDLE:
  - When phr_psdu_in_valid=1 at a rising edge, store the byte as PHR at buffer[0].
  - Latch len = PHR[6:0]. PHR[7] is reserved and is transmitted unchanged.
  - Go to PREAMBLE.
- Capture during a frame:
  - Each further edge with valid=1 writes phr_psdu_in to buffer[wr_ptr] and increments wr_ptr.
  - Capture stops once 1+len bytes are stored; extra bytes are dropped.
  - valid=1 outside IDLE never starts a new frame.
  - A new frame is accepted only once the FSM is back in IDLE.
- Output timing:
  - The first preamble bit appears with out_valid=1 in the cycle after the PHR is sampled (latency 1 clock).
  - PREAMBLE: 8*PREAMBLE_BYTES zero bits (32).
  - SFD: SFD_VALUE LSB first, giving 1,1,1,0,0,1,0,1.
  - PHR: buffer[0] LSB first, 8 bits.
  - PSDU: buffer[1..len], each byte LSB first.
- End of frame:
  - After the last PSDU bit, out_valid=0 and out=0 on the next cycle; FSM returns to IDLE.
  - If len=0, the frame ends after the PHR.
- Length and continuity:
  - Total frame = 8*(PREAMBLE_BYTES+2+len) bits, output continuously with no gaps.
  - Example: len=7 gives 104 bits.
- Underrun: if a PSDU byte is needed before it has been written, abort. out_valid=0 and out=0 from that cycle, and the FSM returns to IDLE. Any partial frame is discarded.
- Outside frames: framing_encoding_out is forced to 0 whenever out_valid=0.
- Reset mid-frame: aborts immediately at the next edge, with all outputs and state at their reset values.
- Simultaneous events: reset has priority over valid.
- Counters: the bit index is 3-bit and wraps 7→0 at each byte boundary, where the byte read pointer increments.

Test Plan:
1. Nominal burst: reset, then one byte per clock with valid=1 for 8 clocks: 07,03,01,05,21,43,65,87. Expect from the next cycle, out_valid=1 for exactly 104 cycles with out bits:
   - 32×0
   - SFD 11100101
   - PHR 0x07: 11100000
   - 03: 11000000
   - 01: 10000000
   - 05: 10100000
   - 21: 10000100
   - 43: 11000010
   - 65: 10100110
   - 87: 11100001
   Then out_valid=0 and out=0.
2. len=0: single byte 0x00 with valid for 1 clock. Expect 48 valid bits: 32 zeros, SFD, then 8 zeros; then idle.
3. PHR[7] set: bytes 0x82,AA,55. Expect PHR bits 01000001, then 01010101, then 10101010; 64 valid bits total.
4. Extra bytes: PHR 0x01 followed by 3 bytes 11,22,33. Only 11 is transmitted; out_valid lasts 56 cycles.
5. Underrun: PHR 0x05 then only 2 PSDU bytes, then valid=0. After the 2 PSDU bytes are sent, out_valid drops to 0 and the FSM returns to IDLE; a following burst frames correctly.
6. Reset mid-frame: assert reset_n=1 during the SFD. out_valid=0 on the next edge; a subsequent burst produces a full, correct frame.
